// File: rtl/bus_defs.sv
// bus_defs: shared types and encodings for the bus sequencer and its arbiter.
// Holds the sequencer state enum, the channel enum and the arbitration mode codes.
package bus_defs;

   // Transfer phases, walked strictly in this order and back to IDLE
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_HOLD   = 3'd4
   } bus_state_t;

   // Requesting channel; the numeric value is what appears on DoneCh
   typedef enum logic {
      CH_FETCH = 1'b0,
      CH_DATA  = 1'b1
   } bus_ch_t;

   // Arbitration mode codes (ARB_MODE parameter values)
   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   // Wait-state counter width, large enough for 0..15 extra ACCESS cycles
   localparam int CNT_W = 4;

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: picks one of the fetch/data requests when the sequencer is idle.
// Fixed mode always prefers data; round-robin mode prefers the channel that was
// not granted last. The grant is combinational so the Ack lands in the request cycle.
module bus_arbiter
   import bus_defs::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       fetchReq,
   input  logic       dataReq,
   input  logic       grantEn,
   input  logic       mode,
   output logic [1:0] grant,
   output bus_ch_t    rrPtr
);

   logic [1:0] grant_s;
   bus_ch_t    rrPtr_r;

   // Grant selection: bit 0 = fetch, bit 1 = data, at most one bit set
   always_comb begin
      grant_s = 2'b00;
      if (!grantEn) begin
         grant_s = 2'b00;
      end else if (fetchReq && dataReq) begin
         if ((mode == ARB_RR) && (rrPtr_r == CH_DATA)) begin
            grant_s = 2'b01;
         end else begin
            grant_s = 2'b10;
         end
      end else if (dataReq) begin
         grant_s = 2'b10;
      end else if (fetchReq) begin
         grant_s = 2'b01;
      end else begin
         grant_s = 2'b00;
      end
   end

   // Remember the most recently granted channel; fetch counts as most recent after reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rrPtr_r <= CH_FETCH;
      end else if (grant_s[1]) begin
         rrPtr_r <= CH_DATA;
      end else if (grant_s[0]) begin
         rrPtr_r <= CH_FETCH;
      end
   end

   assign grant = grant_s;
   assign rrPtr = rrPtr_r;

endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: serialises fetch and load/store requests onto a strobed memory bus
// through the phases IDLE -> ADDR -> SETUP -> ACCESS -> HOLD.
// Optional feature macro: BUS_READY_STRETCH_EN -- when defined, the final ACCESS
// cycle is extended while MemReady is low; otherwise MemReady is ignored.
// Bus strobes, Done/DoneCh and Busy are registered from the next state so they
// are glitch-free and drop immediately on Reset; the Acks are combinational.
module bus_sequencer
   import bus_defs::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_STATES = 1,
   parameter int ARB_MODE    = 0
)(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              FetchReq,
   input  logic [ADDR_W-1:0] FetchAddr,
   input  logic              DataReq,
   input  logic              DataWe,
   input  logic [ADDR_W-1:0] DataAddr,
   input  logic [DATA_W-1:0] DataWrData,
   output logic              FetchAck,
   output logic              DataAck,
   output logic              Done,
   output logic              DoneCh,
   output logic [DATA_W-1:0] RdData,
   output logic              Busy,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWrData,
   input  logic [DATA_W-1:0] MemRdData,
   input  logic              MemReady,
   output logic              ALE,
   output logic              MemEn,
   output logic              ENB,
   output logic              nME,
   output logic              nOE,
   output logic              nWE
);

   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

   bus_state_t       state_r, stateNext_s;
   logic [CNT_W-1:0] cnt_r, cntNext_s;
   logic             we_r;
   bus_ch_t          ch_r;
   logic             capture_s;
   logic             readyOk_s;
   logic [1:0]       grant_s;
   logic             grantEn_s;
   bus_ch_t          unusedRrPtr_s;

   logic aleNext_s, memEnNext_s, enbNext_s, nMeNext_s, nOeNext_s, nWeNext_s;
   logic doneNext_s, doneChNext_s, busyNext_s;

`ifdef BUS_READY_STRETCH_EN
   assign readyOk_s = MemReady;
`else
   logic unusedMemReady_s;
   assign unusedMemReady_s = MemReady;
   assign readyOk_s        = 1'b1;
`endif

   // No grant while held in reset, so the Acks read low during reset
   assign grantEn_s = (state_r == ST_IDLE) && !Reset;

   bus_arbiter u_arb (
      .Clock    (Clock),
      .Reset    (Reset),
      .fetchReq (FetchReq),
      .dataReq  (DataReq),
      .grantEn  (grantEn_s),
      .mode     ((ARB_MODE == 1) ? ARB_RR : ARB_FIXED),
      .grant    (grant_s),
      .rrPtr    (unusedRrPtr_s)
   );

   assign FetchAck = grant_s[0];
   assign DataAck  = grant_s[1];

   // Next-state, wait-counter and read-capture decisions
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (grant_s != 2'b00) begin
               stateNext_s = ST_ADDR;
            end else begin
               stateNext_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            stateNext_s = ST_SETUP;
         end
         ST_SETUP: begin
            stateNext_s = ST_ACCESS;
            cntNext_s   = WAIT_CNT;
         end
         ST_ACCESS: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cntNext_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (readyOk_s) begin
               stateNext_s = ST_HOLD;
               capture_s   = !we_r;
            end else begin
               stateNext_s = ST_ACCESS;
            end
         end
         ST_HOLD: begin
            stateNext_s = ST_IDLE;
         end
         default: begin
            stateNext_s = ST_IDLE;
         end
      endcase
   end

   // Strobe levels for the phase about to be entered
   always_comb begin
      aleNext_s    = 1'b0;
      memEnNext_s  = 1'b0;
      enbNext_s    = 1'b0;
      nMeNext_s    = 1'b1;
      nOeNext_s    = 1'b1;
      nWeNext_s    = 1'b1;
      doneNext_s   = 1'b0;
      doneChNext_s = 1'b0;
      busyNext_s   = (stateNext_s != ST_IDLE);
      case (stateNext_s)
         ST_ADDR: begin
            aleNext_s = 1'b1;
         end
         ST_SETUP: begin
            nMeNext_s = 1'b0;
            if (we_r) begin
               memEnNext_s = 1'b1;
            end else begin
               nOeNext_s = 1'b0;
            end
         end
         ST_ACCESS: begin
            nMeNext_s = 1'b0;
            if (we_r) begin
               memEnNext_s = 1'b1;
               nWeNext_s   = 1'b0;
            end else begin
               nOeNext_s = 1'b0;
               enbNext_s = 1'b1;
            end
         end
         ST_HOLD: begin
            doneNext_s   = 1'b1;
            doneChNext_s = ch_r;
         end
         default: begin
            busyNext_s = (stateNext_s != ST_IDLE);
         end
      endcase
   end

   // State, counter, latched request fields, read capture and registered strobes
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         we_r      <= 1'b0;
         ch_r      <= CH_FETCH;
         MemAddr   <= {ADDR_W{1'b0}};
         MemWrData <= {DATA_W{1'b0}};
         RdData    <= {DATA_W{1'b0}};
         ALE       <= 1'b0;
         MemEn     <= 1'b0;
         ENB       <= 1'b0;
         nME       <= 1'b1;
         nOE       <= 1'b1;
         nWE       <= 1'b1;
         Done      <= 1'b0;
         DoneCh    <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
         if (grant_s[1]) begin
            MemAddr   <= DataAddr;
            MemWrData <= DataWrData;
            we_r      <= DataWe;
            ch_r      <= CH_DATA;
         end else if (grant_s[0]) begin
            MemAddr <= FetchAddr;
            we_r    <= 1'b0;
            ch_r    <= CH_FETCH;
         end
         if (capture_s) begin
            RdData <= MemRdData;
         end
         ALE    <= aleNext_s;
         MemEn  <= memEnNext_s;
         ENB    <= enbNext_s;
         nME    <= nMeNext_s;
         nOE    <= nOeNext_s;
         nWE    <= nWeNext_s;
         Done   <= doneNext_s;
         DoneCh <= doneChNext_s;
         Busy   <= busyNext_s;
      end
   end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: drives a fixed-priority instance (dut0) and a round-robin
// instance (dut1) side by side and checks every output each cycle against a
// transaction-level model: a transfer is described by its grant cycle, and every
// strobe is predicted from the cycle offset since that grant.
module tb_bus_sequencer;

   localparam int AW        = 16;
   localparam int DW        = 16;
   localparam int WS        = 1;
   localparam int XFER_LAST = 4 + WS;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   logic          fReq [2], dReq [2], dWe [2], memReady [2];
   logic [AW-1:0] fAddr [2], dAddr [2], memAddr [2];
   logic [DW-1:0] dWr [2], memRd [2], rdData [2], memWr [2];
   logic          fAck [2], dAck [2], done [2], doneCh [2], busy [2];
   logic          ale [2], memEn [2], enb [2], nMe [2], nOe [2], nWe [2];

   // requester intent, applied to the DUT pins at each falling edge
   bit          wF [2], wD [2], wWe [2];
   logic [15:0] wFA [2], wDA [2], wDW [2];
   bit          rstWant, sticky, rdFixEn;
   logic [15:0] rdFix;

   // transaction-level reference model
   bit          act [2], mCh [2], mWe [2], lastData [2];
   int          ackC [2];
   logic [15:0] mAddr [2], mWr [2], mRd [2];

   // observations used by the directed checks
   int obsAck [2], obsDone [2], nweLow [2];
   int gh0 [$];
   int gh1 [$];
   int expG0 [3];
   int expG1 [3];

   int cyc, total, bad;

   always #5 Clock = ~Clock;

   bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .ARB_MODE(0)) dut0 (
      .Clock(Clock), .Reset(Reset),
      .FetchReq(fReq[0]), .FetchAddr(fAddr[0]), .DataReq(dReq[0]), .DataWe(dWe[0]),
      .DataAddr(dAddr[0]), .DataWrData(dWr[0]), .FetchAck(fAck[0]), .DataAck(dAck[0]),
      .Done(done[0]), .DoneCh(doneCh[0]), .RdData(rdData[0]), .Busy(busy[0]),
      .MemAddr(memAddr[0]), .MemWrData(memWr[0]), .MemRdData(memRd[0]), .MemReady(memReady[0]),
      .ALE(ale[0]), .MemEn(memEn[0]), .ENB(enb[0]), .nME(nMe[0]), .nOE(nOe[0]), .nWE(nWe[0])
   );

   bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .ARB_MODE(1)) dut1 (
      .Clock(Clock), .Reset(Reset),
      .FetchReq(fReq[1]), .FetchAddr(fAddr[1]), .DataReq(dReq[1]), .DataWe(dWe[1]),
      .DataAddr(dAddr[1]), .DataWrData(dWr[1]), .FetchAck(fAck[1]), .DataAck(dAck[1]),
      .Done(done[1]), .DoneCh(doneCh[1]), .RdData(rdData[1]), .Busy(busy[1]),
      .MemAddr(memAddr[1]), .MemWrData(memWr[1]), .MemRdData(memRd[1]), .MemReady(memReady[1]),
      .ALE(ale[1]), .MemEn(memEn[1]), .ENB(enb[1]), .nME(nMe[1]), .nOE(nOe[1]), .nWE(nWe[1])
   );

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // compare one DUT against the model for the current cycle, then advance the model
   task automatic check(input int k);
      bit   g, gData, inX;
      int   off;
      logic eFA, eDA, eAle, eMemEn, eEnb, eNMe, eNOe, eNWe, eDone, eDoneCh, eBusy;
      g = 1'b0; gData = 1'b0; inX = 1'b0; off = -1;
      eFA = 1'b0; eDA = 1'b0; eAle = 1'b0; eMemEn = 1'b0; eEnb = 1'b0;
      eNMe = 1'b1; eNOe = 1'b1; eNWe = 1'b1; eDone = 1'b0; eDoneCh = 1'b0; eBusy = 1'b0;
      if (Reset) begin
         act[k] = 1'b0; lastData[k] = 1'b0;
         mAddr[k] = 16'h0000; mWr[k] = 16'h0000; mRd[k] = 16'h0000;
      end else begin
         inX = act[k] && (cyc - ackC[k] <= XFER_LAST);
         if (inX) begin
            off   = cyc - ackC[k];
            eBusy = (off >= 1);
            eAle  = (off == 1);
            if (off >= 2 && off <= 3 + WS) begin
               eNMe = 1'b0;
               if (mWe[k]) eMemEn = 1'b1; else eNOe = 1'b0;
            end
            if (off >= 3 && off <= 3 + WS) begin
               if (mWe[k]) eNWe = 1'b0; else eEnb = 1'b1;
            end
            if (off == XFER_LAST) begin
               eDone = 1'b1; eDoneCh = mCh[k];
            end
         end else begin
            act[k] = 1'b0;
            g = fReq[k] || dReq[k];
            if (fReq[k] && dReq[k]) gData = (k == 0) || !lastData[k];
            else gData = dReq[k];
            eDA = g && gData;
            eFA = g && !gData;
         end
      end
      chk("FetchAck", k, fAck[k], eFA);
      chk("DataAck", k, dAck[k], eDA);
      chk("ALE", k, ale[k], eAle);
      chk("MemEn", k, memEn[k], eMemEn);
      chk("ENB", k, enb[k], eEnb);
      chk("nME", k, nMe[k], eNMe);
      chk("nOE", k, nOe[k], eNOe);
      chk("nWE", k, nWe[k], eNWe);
      chk("Done", k, done[k], eDone);
      chk("DoneCh", k, doneCh[k], eDoneCh);
      chk("Busy", k, busy[k], eBusy);
      chk("MemAddr", k, memAddr[k], mAddr[k]);
      chk("MemWrData", k, memWr[k], mWr[k]);
      chk("RdData", k, rdData[k], mRd[k]);
      if (fAck[k] || dAck[k]) begin
         obsAck[k] = cyc;
         if (k == 0) gh0.push_back(int'(dAck[k])); else gh1.push_back(int'(dAck[k]));
      end
      if (done[k]) obsDone[k] = cyc;
      if (!nWe[k]) nweLow[k]++;
      if (inX && off == 3 + WS && !mWe[k]) mRd[k] = memRd[k];
      if (g) begin
         act[k] = 1'b1; ackC[k] = cyc; mCh[k] = gData; lastData[k] = gData;
         if (gData) begin
            mWe[k] = dWe[k]; mAddr[k] = dAddr[k]; mWr[k] = dWr[k];
            if (!sticky) wD[k] = 1'b0;
         end else begin
            mWe[k] = 1'b0; mAddr[k] = fAddr[k];
            if (!sticky) wF[k] = 1'b0;
         end
      end
   endtask

   // one clock cycle: drive inputs at the falling edge, check shortly after
   task automatic step(input bit randReq);
      @(negedge Clock);
      Reset = rstWant;
      for (int k = 0; k < 2; k++) begin
         if (randReq) begin
            if (!wF[k] && $urandom_range(0, 2) == 0) begin
               wF[k] = 1'b1; wFA[k] = 16'($urandom);
            end
            if (!wD[k] && $urandom_range(0, 2) == 0) begin
               wD[k] = 1'b1; wDA[k] = 16'($urandom); wDW[k] = 16'($urandom);
               wWe[k] = 1'($urandom_range(0, 1));
            end
         end
         fReq[k] = wF[k]; fAddr[k] = wFA[k];
         dReq[k] = wD[k]; dAddr[k] = wDA[k]; dWe[k] = wWe[k]; dWr[k] = wDW[k];
         memRd[k] = rdFixEn ? rdFix : 16'($urandom);
`ifdef BUS_READY_STRETCH_EN
         memReady[k] = 1'b1;
`else
         memReady[k] = 1'($urandom_range(0, 1));
`endif
      end
      #1;
      for (int k = 0; k < 2; k++) check(k);
      cyc++;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      sticky = 1'b0; rdFixEn = 1'b0; rdFix = 16'h0000; rstWant = 1'b1;
      for (int k = 0; k < 2; k++) begin
         fReq[k] = 1'b0; dReq[k] = 1'b0; dWe[k] = 1'b0; memReady[k] = 1'b1;
         fAddr[k] = 16'h0000; dAddr[k] = 16'h0000; dWr[k] = 16'h0000; memRd[k] = 16'h0000;
         wF[k] = 1'b0; wD[k] = 1'b0; wWe[k] = 1'b0;
         wFA[k] = 16'h0000; wDA[k] = 16'h0000; wDW[k] = 16'h0000;
         act[k] = 1'b0; mCh[k] = 1'b0; mWe[k] = 1'b0; lastData[k] = 1'b0; ackC[k] = 0;
         mAddr[k] = 16'h0000; mWr[k] = 16'h0000; mRd[k] = 16'h0000;
         obsAck[k] = -1; obsDone[k] = -1; nweLow[k] = 0;
      end
      expG0 = '{1, 1, 1};
      expG1 = '{1, 0, 1};

      // reset with both requests pending: Acks and strobes stay idle
      wF = '{1'b1, 1'b1}; wD = '{1'b1, 1'b1};
      step(1'b0); step(1'b0);
      wF = '{1'b0, 1'b0}; wD = '{1'b0, 1'b0};
      step(1'b0);
      rstWant = 1'b0;
      step(1'b0); step(1'b0);

      // single fetch read, fixed read data
      rdFixEn = 1'b1; rdFix = 16'hBEEF;
      wF = '{1'b1, 1'b1}; wFA = '{16'h0040, 16'h0040};
      obsAck = '{-1, -1}; obsDone = '{-1, -1};
      repeat (8) step(1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("fetch_latency", k, obsDone[k] - obsAck[k], 5);
         chk("fetch_rddata", k, rdData[k], 16'hBEEF);
      end

      // single store: two nWE-low cycles, read data untouched
      nweLow = '{0, 0};
      wD = '{1'b1, 1'b1}; wWe = '{1'b1, 1'b1};
      wDA = '{16'h1234, 16'h1234}; wDW = '{16'h5A5A, 16'h5A5A};
      repeat (8) step(1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("store_nwe_low_cycles", k, nweLow[k], 2);
         chk("store_rddata_kept", k, rdData[k], 16'hBEEF);
         chk("store_memwrdata", k, memWr[k], 16'h5A5A);
         chk("store_memaddr", k, memAddr[k], 16'h1234);
      end

      // both channels held for three transfers after a fresh reset
      rstWant = 1'b1; step(1'b0); rstWant = 1'b0;
      gh0.delete(); gh1.delete();
      sticky = 1'b1; wWe = '{1'b0, 1'b0};
      wF = '{1'b1, 1'b1}; wD = '{1'b1, 1'b1};
      wFA = '{16'h0A00, 16'h0A00}; wDA = '{16'h0D00, 16'h0D00};
      repeat (18) step(1'b0);
      sticky = 1'b0;
      wF = '{1'b0, 1'b0}; wD = '{1'b0, 1'b0};
      repeat (4) step(1'b0);
      chk("arb_grant_count", 0, gh0.size(), 3);
      chk("arb_grant_count", 1, gh1.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < gh0.size()) chk("arb_fixed_grant", i, gh0[i], expG0[i]);
         if (i < gh1.size()) chk("arb_rr_grant", i, gh1[i], expG1[i]);
      end

      // randomized traffic, then drain
      rdFixEn = 1'b0;
      repeat (600) step(1'b1);
      repeat (30) step(1'b0);

      // reset during ACCESS aborts without Done; the next request is served normally
      wF = '{1'b1, 1'b1}; wFA = '{16'h0100, 16'h0100};
      repeat (4) step(1'b0);
      rstWant = 1'b1;
      obsDone = '{-1, -1};
      step(1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("abort_nme", k, nMe[k], 1'b1);
         chk("abort_noe", k, nOe[k], 1'b1);
         chk("abort_enb", k, enb[k], 1'b0);
      end
      rstWant = 1'b0;
      repeat (8) step(1'b0);
      for (int k = 0; k < 2; k++) chk("abort_no_done", k, obsDone[k], -1);
      wF = '{1'b1, 1'b1}; wFA = '{16'h0200, 16'h0200};
      obsAck = '{-1, -1}; obsDone = '{-1, -1};
      repeat (8) step(1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("after_abort_latency", k, obsDone[k] - obsAck[k], 5);
         chk("after_abort_memaddr", k, memAddr[k], 16'h0200);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 16, width of the memory address.
REQ-002 SHALL have parameter DATA_W, 16, width of the memory data.
REQ-003 SHALL have parameter WAIT_STATES, 1, extra ACCESS cycles, legal range 0..15.
REQ-004 SHALL have parameter ARB_MODE, 0, arbitration mode: 0 = fixed data-over-fetch, 1 = round-robin.
REQ-005 SHALL have ports:
  Clock  in  1  single clock; all state changes on rising edge.
  Reset  in  1  asynchronous, active-high reset.
  FetchReq  in  1  instruction fetch request.
  FetchAddr  in  ADDR_W  fetch address.
  DataReq  in  1  load/store request.
  DataWe  in  1  1 = store, 0 = load.
  DataAddr  in  ADDR_W  load/store address.
  DataWrData  in  DATA_W  store data.
  FetchAck  out  1  one-cycle pulse when a fetch is accepted.
  DataAck  out  1  one-cycle pulse when a data request is accepted.
  Done  out  1  one-cycle pulse when a transfer completes.
  DoneCh  out  1  channel of the completing transfer: 0 = fetch, 1 = data.
  RdData  out  DATA_W  captured read data.
  Busy  out  1  high in every state except IDLE.
  MemAddr  out  ADDR_W  latched address.
  MemWrData  out  DATA_W  latched store data.
  MemRdData  in  DATA_W  memory read data.
  MemReady  in  1  memory ready; used only under REQ-020.
  ALE, MemEn, ENB  out  1 each  active-high bus strobes.
  nME, nOE, nWE  out  1 each  active-low bus strobes.

Function
REQ-006 SHALL implement states IDLE, ADDR, SETUP, ACCESS, HOLD, advancing IDLE->ADDR->SETUP->ACCESS->HOLD->IDLE.
REQ-007 In IDLE with any request pending, SHALL pulse the winner's Ack in that same cycle (combinational from state and requests), latch its address, DataWe and DataWrData, and move to ADDR.
REQ-008 ADDR: ALE=1; MemAddr valid; all active-low strobes high.
REQ-009 SETUP: nME=0; read: nOE=0; write: MemEn=1, MemWrData driven.
REQ-010 ACCESS: SHALL last exactly WAIT_STATES+1 cycles via a down-counter; nME=0; read: nOE=0, ENB=1; write: MemEn=1, nWE=0.
REQ-011 SHALL capture MemRdData into RdData on the last ACCESS cycle of a read; RdData holds until the next read completes and is unchanged by writes.
REQ-012 HOLD: all strobes inactive; Done=1; DoneCh identifies the channel.
REQ-013 Latency: Done SHALL assert exactly 4+WAIT_STATES cycles after the Ack cycle; back-to-back transfers SHALL cost 5+WAIT_STATES cycles each.
REQ-014 ARB_MODE=0: on simultaneous requests, data SHALL win.
REQ-015 ARB_MODE=1: on simultaneous requests, the channel not granted most recently SHALL win; after reset, fetch is treated as most recent.
REQ-016 Requests SHALL be level-held by the requester until its Ack; requests arriving outside IDLE SHALL wait, not be dropped.
REQ-017 nWE and nOE SHALL never be low in the same cycle; ALE SHALL never be high while nME is low.

Reset
REQ-018 On Reset=1, asynchronously: state IDLE, counter 0, ALE/MemEn/ENB/Ack/Done/Busy/DoneCh=0, nME/nOE/nWE=1, MemAddr/MemWrData/RdData=0, round-robin pointer = fetch.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no Done pulse; the first request after release is arbitrated afresh.

Configuration
REQ-020 Macro BUS_READY_STRETCH_EN defined: when the counter reaches zero and MemReady=0, SHALL remain in ACCESS with strobes held until MemReady=1, and the capture in REQ-011 occurs in the MemReady=1 cycle.
REQ-021 BUS_READY_STRETCH_EN undefined: MemReady SHALL be ignored and ACCESS length fixed per REQ-010.

Structure
REQ-022 A shared package bus_defs SHALL hold the bus_state_t enum, the channel enum (CH_FETCH, CH_DATA) and the ARB_MODE encodings.
REQ-023 Arbitration SHALL be a sub-module bus_arbiter (inputs: two requests, grant-enable, mode; outputs: one-hot grant, round-robin pointer).

Verification
REQ-024 WAIT_STATES=1, FetchReq alone, FetchAddr=0x0040, MemRdData=0xBEEF -> FetchAck at cycle 0, ALE at cycle 1, Done at cycle 5, DoneCh=0, RdData=0xBEEF.
REQ-025 Store DataAddr=0x1234, DataWrData=0x5A5A -> nWE low for exactly 2 cycles, MemEn high in SETUP and ACCESS, nOE high throughout, RdData unchanged.
REQ-026 ARB_MODE=0, both requests held 3 transfers -> grants data, data, data; ARB_MODE=1 -> grants data, fetch, data.
REQ-027 Reset pulsed during ACCESS -> all strobes inactive in the same cycle, no Done pulse, the next request is served normally.
REQ-028 BUS_READY_STRETCH_EN, MemReady low 3 extra cycles -> ACCESS lasts 5 cycles and Done arrives 3 cycles later than in REQ-024; without the macro, Done timing matches REQ-024.
